uart_mem_cmd: RTL and testbench

- Command front-end between the UART receiver/transmitter and the 32K x 16 staticRAM block.
- Parses a byte stream from the UART RX into write and read commands.
- Write commands drive the RAM port (wea/addra/dina).
- Read commands fetch douta and return it as two bytes through the UART TX handshake, high byte first.

---
 rtl/uart_mem_cmd.sv | 169 ++++++++++++++++
 tb/tb_uart_mem_cmd.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_cmd.sv
// uart_mem_cmd: byte-stream command parser between a UART and a 16-bit RAM.
// 'W' ah al dh dl writes one word; 'R' ah al reads one word back as two bytes.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   tx_ready              transmitter idle
//   tx_data, tx_start     byte to send and its one-cycle request
//   mem_we/addr/din/dout  RAM port (wea/addra/dina/douta)
//   busy, err             not-IDLE flag, one-cycle error pulse
module uart_mem_cmd #(
    parameter int          ADDR_W  = 15,
    parameter logic [7:0]  CMD_WR  = 8'h57,
    parameter logic [7:0]  CMD_RD  = 8'h52,
    parameter int          RD_LAT  = 1,
    parameter int          TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L, S_WRITE,
        S_RD_WAIT, S_TX_H, S_TX_H_WAIT, S_TX_L, S_TX_L_WAIT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_op_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din_hi;
    logic [7:0]        r_rdata_lo;
    logic [7:0]        r_tx_data;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_din;

    logic w_to_hit;
    logic w_take;
    logic w_cmd;
    logic w_cnt_inc;
    logic w_err;
    logic w_tx_start;

    // Frame-state expiry: a byte arriving on the same cycle is not taken.
    assign w_to_hit = (r_cnt == TO_LAST);

    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_cmd      = 1'b0;
        w_cnt_inc  = 1'b0;
        w_err      = 1'b0;
        w_tx_start = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                    w_cmd  = 1'b1;
                    w_next = S_ADDR_H;
                end
            end
            S_ADDR_H, S_ADDR_L, S_DATA_H, S_DATA_L: begin
                w_cnt_inc = 1'b1;
                if (w_to_hit) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end else if (rx_valid) begin
                    w_take = 1'b1;
                    unique case (r_state)
                        S_ADDR_H: w_next = S_ADDR_L;
                        S_ADDR_L: w_next = r_op_rd ? S_RD_WAIT : S_DATA_H;
                        S_DATA_H: w_next = S_DATA_L;
                        default:  w_next = S_WRITE;
                    endcase
                end
            end
            S_WRITE: begin
                w_err  = rx_valid;
                w_next = S_IDLE;
            end
            S_RD_WAIT: begin
                w_err     = rx_valid;
                w_cnt_inc = 1'b1;
                if (r_cnt == LAT_LAST) w_next = S_TX_H;
            end
            S_TX_H, S_TX_L: begin
                w_err = rx_valid;
                if (tx_ready) begin
                    w_tx_start = 1'b1;
                    w_next = (r_state == S_TX_H) ? S_TX_H_WAIT : S_TX_L_WAIT;
                end
            end
            S_TX_H_WAIT, S_TX_L_WAIT: begin
                w_err = rx_valid;
                // First cycle after tx_start: tx_ready may still be stale.
                w_cnt_inc = (r_cnt == '0);
                if (r_cnt != '0 && tx_ready)
                    w_next = (r_state == S_TX_H_WAIT) ? S_TX_L : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op_rd    <= 1'b0;
            r_addr     <= '0;
            r_din_hi   <= '0;
            r_rdata_lo <= '0;
            r_tx_data  <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state || !w_cnt_inc)
                r_cnt <= (w_next != r_state) ? '0 : r_cnt;
            else
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_cmd) r_op_rd <= (rx_data == CMD_RD);
            if (w_take) begin
                unique case (r_state)
                    S_ADDR_H: r_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
                    S_ADDR_L: begin
                        r_addr[7:0] <= rx_data;
                        if (r_op_rd)
                            r_mem_addr <= {r_addr[ADDR_W-1:8], rx_data};
                    end
                    S_DATA_H: r_din_hi <= rx_data;
                    default: begin
                        // RAM port only changes when a full frame commits.
                        r_mem_addr <= r_addr;
                        r_mem_din  <= {r_din_hi, rx_data};
                    end
                endcase
            end
            if (r_state == S_RD_WAIT && w_next == S_TX_H) begin
                r_tx_data  <= mem_dout[15:8];
                r_rdata_lo <= mem_dout[7:0];
            end
            if (r_state == S_TX_H_WAIT && w_next == S_TX_L)
                r_tx_data <= r_rdata_lo;
        end
    end

    assign mem_we   = (r_state == S_WRITE);
    assign busy     = (r_state != S_IDLE);
    assign err      = w_err;
    assign tx_start = w_tx_start;
    assign tx_data  = r_tx_data;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_uart_mem_cmd.sv
// tb_uart_mem_cmd: directed bench driving two uart_mem_cmd instances
// (RD_LAT=1 and RD_LAT=2) with shared RX stimulus and private RAM/TX models.
module tb_uart_mem_cmd;

    localparam int TO  = 64;
    localparam int TXB = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_hold;
    int          cyc = 0;

    logic        tx_ready1, tx_ready2;
    logic [7:0]  tx_data1, tx_data2;
    logic        tx_start1, tx_start2;
    logic        mem_we1, mem_we2;
    logic [14:0] mem_addr1, mem_addr2;
    logic [15:0] mem_din1, mem_din2;
    logic [15:0] mem_dout1, mem_dout2;
    logic        busy1, busy2;
    logic        err1, err2;

    uart_mem_cmd #(.RD_LAT(1), .TIMEOUT(TO)) dut1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready1), .tx_data(tx_data1), .tx_start(tx_start1),
        .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
        .mem_dout(mem_dout1), .busy(busy1), .err(err1)
    );

    uart_mem_cmd #(.RD_LAT(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready2), .tx_data(tx_data2), .tx_start(tx_start2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2),
        .mem_dout(mem_dout2), .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models
    logic [15:0] mem1 [0:32767];
    logic [15:0] mem2 [0:32767];
    logic [15:0] rd1, rd2a, rd2b;
    initial begin
        for (int i = 0; i < 32768; i++) begin
            mem1[i] = 16'h0;
            mem2[i] = 16'h0;
        end
    end
    always @(posedge clk) begin
        if (mem_we1) mem1[mem_addr1] <= mem_din1;
        if (mem_we2) mem2[mem_addr2] <= mem_din2;
        rd1  <= mem1[mem_addr1];
        rd2a <= mem2[mem_addr2];
        rd2b <= rd2a;
    end
    assign mem_dout1 = rd1;
    assign mem_dout2 = rd2b;

    // Transmitter models: busy TXB cycles after each tx_start
    int tb1 = 0, tb2 = 0;
    always @(posedge clk) begin
        if (tx_start1) tb1 <= TXB; else if (tb1 != 0) tb1 <= tb1 - 1;
        if (tx_start2) tb2 <= TXB; else if (tb2 != 0) tb2 <= tb2 - 1;
    end
    assign tx_ready1 = (tb1 == 0) && !tx_hold;
    assign tx_ready2 = (tb2 == 0) && !tx_hold;

    // Monitors
    typedef struct packed {
        int          c;
        logic [14:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t        wq1[$], wq2[$];
    logic [7:0] txq1[$], txq2[$];
    int         txc1[$], txc2[$];
    int         e1 = 0, e2 = 0, bad1 = 0, bad2 = 0;

    always @(negedge clk) begin
        if (mem_we1) wq1.push_back('{cyc, mem_addr1, mem_din1});
        if (mem_we2) wq2.push_back('{cyc, mem_addr2, mem_din2});
        if (tx_start1) begin
            txq1.push_back(tx_data1);
            txc1.push_back(cyc);
            if (!tx_ready1) bad1++;
        end
        if (tx_start2) begin
            txq2.push_back(tx_data2);
            txc2.push_back(cyc);
            if (!tx_ready2) bad2++;
        end
        if (err1) e1++;
        if (err2) e2++;
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int last_s = 0;
    int eb1, eb2;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        last_s   = cyc;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clr();
        wq1.delete(); wq2.delete();
        txq1.delete(); txq2.delete();
        txc1.delete(); txc2.delete();
        eb1 = e1; eb2 = e2;
    endtask

    task automatic wr_chk(input string tag, input logic [15:0] a,
                          input logic [15:0] d);
        clr();
        send(8'h57); send(a[15:8]); send(a[7:0]);
        send(d[15:8]); send(d[7:0]);
        idle(3);
        @(negedge clk);
        chk({tag, "_n1"}, wq1.size(), 1);
        chk({tag, "_n2"}, wq2.size(), 1);
        chk({tag, "_a1"}, wq1[0].a, a[14:0]);
        chk({tag, "_d1"}, wq1[0].d, d);
        chk({tag, "_d2"}, wq2[0].d, d);
        chk({tag, "_t1"}, wq1[0].c, last_s + 1);
        chk({tag, "_busy"}, {busy1, busy2}, 2'b00);
        chk({tag, "_err"}, (e1 - eb1) + (e2 - eb2), 0);
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 3000; k++) begin
            if (txq1.size() >= n && txq2.size() >= n) break;
            @(posedge clk);
        end
        @(negedge clk);
        chk("tx_cnt1", txq1.size(), n);
        chk("tx_cnt2", txq2.size(), n);
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a,
                          input logic [15:0] d);
        clr();
        send(8'h52); send(a[15:8]); send(a[7:0]);
        wait_tx(2);
        chk({tag, "_h1"}, txq1[0], d[15:8]);
        chk({tag, "_l1"}, txq1[1], d[7:0]);
        chk({tag, "_h2"}, txq2[0], d[15:8]);
        chk({tag, "_l2"}, txq2[1], d[7:0]);
        idle(TXB + 10);
        @(negedge clk);
        chk({tag, "_busy"}, {busy1, busy2}, 2'b00);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_hold  = 1'b0;
        idle(3);
        @(negedge clk);
        chk("rst_ctl", {tx_start1, mem_we1, busy1, err1}, 4'b0);
        chk("rst_dat", {tx_data1, mem_addr1, mem_din1}, 39'h0);
        chk("rst_ctl2", {tx_start2, mem_we2, busy2, err2}, 4'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);

        wr_chk("w0001", 16'h0001, 16'hAAAA);
        wr_chk("w0002", 16'h0002, 16'h5555);
        wr_chk("w0003", 16'h0003, 16'hCCCC);
        wr_chk("w0004", 16'h0004, 16'h3333);
        wr_chk("w0005", 16'h0005, 16'h1111);
        rd_chk("r0002", 16'h0002, 16'h5555);
        chk("start_rdy", bad1 + bad2, 0);

        wr_chk("w7fff", 16'h7FFF, 16'h1234);
        rd_chk("r7fff", 16'h7FFF, 16'h1234);
        chk("lat2_extra", txc2[0] - txc1[0], 1);
        chk("addr_hold", mem_addr1, 15'h7FFF);

        // Abandoned write frame times out
        wr_chk("w0006", 16'h0006, 16'h7777);
        clr();
        send(8'h57); send(8'h00); send(8'h06); send(8'hBE);
        idle(TO + 10);
        @(negedge clk);
        chk("to_err1", e1 - eb1, 1);
        chk("to_err2", e2 - eb2, 1);
        chk("to_nowr", wq1.size() + wq2.size(), 0);
        chk("to_busy", {busy1, busy2}, 2'b00);
        rd_chk("r0006", 16'h0006, 16'h7777);

        // Stalled transmitter plus a byte dropped mid-read
        clr();
        tx_hold = 1'b1;
        send(8'h52); send(8'h00); send(8'h03);
        idle(500);
        @(negedge clk);
        chk("hold_busy", {busy1, busy2}, 2'b11);
        chk("hold_notx", txq1.size() + txq2.size(), 0);
        send(8'h57);
        idle(2);
        @(negedge clk);
        chk("drop_err1", e1 - eb1, 1);
        chk("drop_err2", e2 - eb2, 1);
        @(posedge clk);
        #1 tx_hold = 1'b0;
        wait_tx(2);
        chk("hold_h", txq1[0], 8'hCC);
        chk("hold_l", txq1[1], 8'hCC);
        chk("hold_h2", txq2[0], 8'hCC);
        chk("hold_l2", txq2[1], 8'hCC);
        idle(TXB + 10);
        @(negedge clk);
        chk("drop_nowr", wq1.size() + wq2.size(), 0);
        chk("drop_busy", {busy1, busy2}, 2'b00);
        chk("start_rdy2", bad1 + bad2, 0);

        // Reset in DATA_L abandons the write
        clr();
        send(8'h57); send(8'h00); send(8'h07); send(8'h12);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(2);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctl", {tx_start1, mem_we1, busy1, err1}, 4'b0);
        chk("mid_rst_dat", {tx_data1, mem_addr1, mem_din1}, 39'h0);
        chk("mid_rst_b2", busy2, 1'b0);
        idle(5);
        send(8'h41);
        idle(5);
        @(negedge clk);
        chk("junk_err", (e1 - eb1) + (e2 - eb2), 0);
        chk("junk_busy", {busy1, busy2}, 2'b00);
        chk("rst_nowr", wq1.size() + wq2.size(), 0);
        wr_chk("w0007", 16'h0007, 16'h4321);
        rd_chk("r0007", 16'h0007, 16'h4321);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
